// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive responder: oversamples the SPI pins in the clk domain,
// deserialises MSB-first words and presents them on a valid/ready stream.
module spi_slave_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_cs,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  frame_error,
    output logic                  overrun
);

    localparam int unsigned CW   = $clog2(DATA_WIDTH + 1);
    localparam int unsigned SETW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        S_RESYNC,
        S_IDLE,
        S_ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   cs_dly_q, sclk_dly_q;
    logic [SETW-1:0]        settle_q, settle_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   fs_q, fs_d, fe_q, fe_d, ferr_q, ferr_d, ov_q, ov_d;

    logic cs_s, sclk_s, mosi_s;
    logic sclk_rise, cs_rise, cs_fall, settled;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign cs_rise   = cs_s & ~cs_dly_q;
    assign cs_fall   = ~cs_s & cs_dly_q;
    // The cs chain resets to 1, so RESYNC waits until the chain has been
    // refilled from the pin before trusting a high level.
    assign settled   = (settle_q == SETW'(SYNC_STAGES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_dly_q    <= 1'b1;
            sclk_dly_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_dly_q    <= cs_s;
            sclk_dly_q  <= sclk_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q <= '0;
            state_q  <= S_RESYNC;
            cnt_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            fe_q     <= 1'b0;
            ferr_q   <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            settle_q <= settle_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
            fe_q     <= fe_d;
            ferr_q   <= ferr_d;
            ov_q     <= ov_d;
        end
    end

    always_comb begin
        settle_d = settled ? settle_q : settle_q + 1'b1;
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        fs_d     = 1'b0;
        fe_d     = 1'b0;
        ferr_d   = 1'b0;
        ov_d     = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_RESYNC: begin
                if (settled && cs_s) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cs_fall) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                    shift_d = '0;
                    fs_d    = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (sclk_rise) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        cnt_d = '0;
                        if (!valid_q || ready) begin
                            data_d  = shift_d;
                            valid_d = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // A coincident cs rise is handled after the clock edge above.
                if (cs_rise) begin
                    state_d = S_IDLE;
                    fe_d    = 1'b1;
                    ferr_d  = (cnt_d != '0);
                    cnt_d   = '0;
                end
            end
            default: state_d = S_RESYNC;
        endcase
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_start = fs_q;
    assign frame_end   = fe_q;
    assign frame_error = ferr_q;
    assign overrun     = ov_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: expected words are queued as they are
// shifted in and compared when the DUT hands them over.
module tb_spi_slave_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_cs, spi_clk, spi_mosi;
    logic [7:0] data;
    logic       valid, ready;
    logic       frame_start, frame_end, frame_error, overrun;

    int n_checks = 0;
    int n_errors = 0;
    int n_fs = 0, n_fe = 0, n_ferr = 0, n_ov = 0, n_words = 0, n_coinc = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    spi_slave_rx #(.SYNC_STAGES(2), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_cs     (spi_cs),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: count pulses and pop the scoreboard on each accepted word.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_start) n_fs++;
            if (frame_end) n_fe++;
            if (frame_error) n_ferr++;
            if (frame_error && frame_end) n_coinc++;
            if (overrun) n_ov++;
            if (valid && ready) begin
                n_words++;
                check("word_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() > 0) check("word_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 ready = r;
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        cycles(6);
    endtask

    task automatic cs_high();
        cycles(4);
        spi_cs = 1'b1;
        cycles(10);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            cycles(4);
            spi_clk = 1'b1;
            cycles(4);
            spi_clk = 1'b0;
        end
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (valid !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, valid}, 32'd1);
    endtask

    int fs0, fe0, ferr0, ov0, w0, c0;

    task automatic snap();
        fs0 = n_fs; fe0 = n_fe; ferr0 = n_ferr; ov0 = n_ov; w0 = n_words; c0 = n_coinc;
    endtask

    initial begin
        rst = 1'b1; spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_fs", {31'd0, frame_start}, 32'd0);
        check("rst_fe", {31'd0, frame_end}, 32'd0);
        check("rst_ferr", {31'd0, frame_error}, 32'd0);
        check("rst_ov", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        cycles(10);

        // Single word
        snap();
        cs_low();
        exp_q.push_back(8'hA5); send_bits(8'hA5, 8);
        cs_high();
        check("single_fs", n_fs - fs0, 1);
        check("single_fe", n_fe - fe0, 1);
        check("single_ferr", n_ferr - ferr0, 0);
        check("single_ov", n_ov - ov0, 0);
        check("single_words", n_words - w0, 1);

        // Burst
        snap();
        cs_low();
        exp_q.push_back(8'h55); send_bits(8'h55, 8);
        exp_q.push_back(8'h33); send_bits(8'h33, 8);
        exp_q.push_back(8'h0F); send_bits(8'h0F, 8);
        cs_high();
        check("burst_fs", n_fs - fs0, 1);
        check("burst_fe", n_fe - fe0, 1);
        check("burst_ferr", n_ferr - ferr0, 0);
        check("burst_words", n_words - w0, 3);

        // Backpressure
        snap();
        set_ready(1'b0);
        cs_low();
        exp_q.push_back(8'h3C); send_bits(8'h3C, 8);
        cs_high();
        wait_valid("bp_valid_timeout");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_valid_hold", {31'd0, valid}, 32'd1);
            check("bp_data_hold", {24'd0, data}, 32'h3C);
        end
        set_ready(1'b1);
        repeat (2) @(negedge clk);
        check("bp_valid_clear", {31'd0, valid}, 32'd0);
        check("bp_words", n_words - w0, 1);

        // Overrun
        snap();
        set_ready(1'b0);
        cs_low();
        exp_q.push_back(8'h11); send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        cs_high();
        @(negedge clk);
        check("ov_pulse", n_ov - ov0, 1);
        check("ov_valid", {31'd0, valid}, 32'd1);
        check("ov_data", {24'd0, data}, 32'h11);
        check("ov_no_accept", n_words - w0, 0);
        set_ready(1'b1);
        cycles(5);
        @(negedge clk);
        check("ov_words", n_words - w0, 1);
        check("ov_valid_clear", {31'd0, valid}, 32'd0);

        // Truncated word, then a clean frame
        snap();
        cs_low();
        send_bits(8'hFF, 5);
        cs_high();
        check("trunc_fe", n_fe - fe0, 1);
        check("trunc_ferr", n_ferr - ferr0, 1);
        check("trunc_coinc", n_coinc - c0, 1);
        check("trunc_words", n_words - w0, 0);
        snap();
        cs_low();
        exp_q.push_back(8'hC3); send_bits(8'hC3, 8);
        cs_high();
        check("after_trunc_words", n_words - w0, 1);
        check("after_trunc_ferr", n_ferr - ferr0, 0);

        // Reset mid-frame
        cs_low();
        send_bits(8'hE0, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        cycles(2);
        #1 rst = 1'b0;
        snap();
        send_bits(8'h00, 5);
        cs_high();
        check("rstmid_words", n_words - w0, 0);
        check("rstmid_fs", n_fs - fs0, 0);
        check("rstmid_fe", n_fe - fe0, 0);
        check("rstmid_ferr", n_ferr - ferr0, 0);
        snap();
        cs_low();
        exp_q.push_back(8'h7E); send_bits(8'h7E, 8);
        cs_high();
        check("rstmid_new_words", n_words - w0, 1);
        check("rstmid_new_data", {24'd0, data}, 32'h7E);
        check("rstmid_new_fs", n_fs - fs0, 1);

        cycles(20);
        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
